// File: rtl/modn_down_counter_pkg.sv
// Shared constants and helpers for the modulo-N down counter.
package modn_down_counter_pkg;

  localparam int unsigned DEFAULT_N = 5;

  // Number of bits needed to hold the values 0..n-1, i.e. ceil(log2(n)).
  function automatic int unsigned count_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/modn_down_counter_tff_cell.sv
// Single toggle flip-flop with asynchronous active-high clear.
module tff_cell (
  input  logic T,
  input  logic Clock,
  input  logic Reset,
  output logic Out
);

  logic out_q;

  // Flip the stored bit on every edge where T is set.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_q <= 1'b0;
    end else if (T) begin
      out_q <= ~out_q;
    end
  end

  assign Out = out_q;

endmodule

// File: rtl/modn_down_counter.sv
// Cascadable modulo-N down counter built from per-bit toggle cells.
module modn_down_counter
  import modn_down_counter_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N,
  parameter int unsigned W = count_width(N)
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         En,
  input  logic         Load,
  input  logic [W-1:0] D,
  output logic [W-1:0] Y,
  output logic         Borrow,
  output logic         Tc
);

  localparam logic [W-1:0] MAX_VAL = W'(N - 1);

  // Reject unsupported moduli and a width that does not match the modulus.
  if ((N < 2) || (N > 256) || (W != count_width(N))) begin : g_bad_cfg
    $error("modn_down_counter: illegal N/W combination");
  end

  logic [W-1:0] y_q;
  logic [W-1:0] y_d;
  logic [W-1:0] t;
  logic         tc_q;
  logic         tc_d;

  // Next count by priority: clamped load, wrap, decrement, illegal-state recovery, hold.
  always_comb begin
    y_d  = y_q;
    tc_d = 1'b0;
    if (Load) begin
      y_d = (D > MAX_VAL) ? MAX_VAL : D;
    end else if (En) begin
      if (y_q == '0) begin
        y_d  = MAX_VAL;
        tc_d = 1'b1;
      end else if (y_q > MAX_VAL) begin
        y_d = MAX_VAL;
      end else begin
        y_d = y_q - W'(1);
      end
    end
  end

  // Toggle exactly the bits that differ between current and next count.
  assign t = y_q ^ y_d;

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    tff_cell u_tff (
      .T     (t[i]),
      .Clock (Clock),
      .Reset (Reset),
      .Out   (y_q[i])
    );
  end

  // One-cycle terminal-count pulse following each wrap edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign Y      = y_q;
  assign Tc     = tc_q;
  assign Borrow = En & (y_q == '0);

endmodule
